// File: rtl/multicore_run_controller_pkg.sv
// Shared types and limits for the multicore run controller.
// Latency: n/a; backpressure: n/a.
package multicore_ctrl_pkg;

    localparam int MAX_CORES = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } run_state_t;

    typedef enum logic {
        BROADCAST = 1'b0,
        STAGGER   = 1'b1
    } launch_mode_t;

endpackage

// File: rtl/multicore_run_controller_if.sv
// Board/core-array signal bundle for the run controller; slave is the controller's view.
// Latency: n/a; backpressure: none, start is an edge request gated by processor_ready.
interface multicore_run_controller_if #(
    parameter int CORE_COUNT = 4,
    parameter int CYCLE_W    = 32
);
    logic                  startN;
    logic                  mode_stagger;
    logic [CORE_COUNT-1:0] core_enable;
    logic [CORE_COUNT-1:0] core_done;
    logic [CORE_COUNT-1:0] core_start;
    logic                  processor_ready;
    logic                  processDone;
    logic                  timed_out;
    logic [CORE_COUNT-1:0] done_mask;
    logic [CYCLE_W-1:0]    cycle_count;

    modport master (
        output startN, mode_stagger, core_enable, core_done,
        input  core_start, processor_ready, processDone, timed_out, done_mask, cycle_count
    );

    modport slave (
        input  startN, mode_stagger, core_enable, core_done,
        output core_start, processor_ready, processDone, timed_out, done_mask, cycle_count
    );
endinterface

// File: rtl/multicore_run_controller_done_collector.sv
// Sticky per-core completion mask with a combinational all-done look-ahead on the next mask.
// Latency: mask updates one cycle after capture; all_done is same-cycle; backpressure: none.
module done_collector #(
    parameter int CORE_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  capture,
    input  logic [CORE_COUNT-1:0] active_mask,
    input  logic [CORE_COUNT-1:0] core_done,
    output logic [CORE_COUNT-1:0] done_mask,
    output logic                  all_done
);
    logic [CORE_COUNT-1:0] mask_next;

    always_comb begin
        mask_next = done_mask;
        if (capture) begin
            mask_next = done_mask | (core_done & active_mask);
        end
    end

    // Looking at the next mask lets the FSM finish on the edge that samples the last done.
    assign all_done = ((mask_next & active_mask) == active_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_mask <= '0;
        end else if (clear) begin
            done_mask <= '0;
        end else begin
            done_mask <= mask_next;
        end
    end
endmodule

// File: rtl/multicore_run_controller.sv
// Launches enabled cores (broadcast or staggered) on a startN falling edge and reports system done.
// Latency: core_start one cycle after the edge; backpressure: edges outside IDLE/DONE are dropped.
module multicore_run_controller
    import multicore_ctrl_pkg::*;
#(
    parameter int CORE_COUNT = 4,
    parameter int CYCLE_W    = 32,
    parameter int TIMEOUT    = 0
) (
    input logic                        clk,
    input logic                        rst,
    multicore_run_controller_if.slave  bus
);
    localparam int                  IDX_W    = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(CORE_COUNT - 1);
    localparam logic [CYCLE_W-1:0]  TO_LAST  = CYCLE_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    if (CORE_COUNT < 1 || CORE_COUNT > MAX_CORES) begin : g_cfg_check
        $error("CORE_COUNT out of range");
    end

    run_state_t            state;
    launch_mode_t          mode;
    logic [CORE_COUNT-1:0] active_mask;
    logic [IDX_W-1:0]      idx;
    logic                  startN_q;
    logic [CORE_COUNT-1:0] core_start_r;
    logic                  ready_r;
    logic                  done_r;
    logic                  timed_out_r;
    logic [CYCLE_W-1:0]    cycle_cnt;

    logic start_edge;
    logic accept;
    logic in_run;
    logic check_done;
    logic all_done;
    logic timeout_hit;

    assign start_edge  = startN_q & ~bus.startN;
    assign accept      = start_edge && ((state == IDLE) || (state == DONE)) && (|bus.core_enable);
    assign in_run      = (state == LAUNCH) || (state == RUN);
    // A staggered launch is still handing out starts, so completion is only judged once in RUN.
    assign check_done  = (state == RUN) || ((state == LAUNCH) && (mode == BROADCAST));
    assign timeout_hit = (TIMEOUT != 0) && in_run && (cycle_cnt == TO_LAST);

    done_collector #(
        .CORE_COUNT (CORE_COUNT)
    ) u_done_collector (
        .clk         (clk),
        .rst         (rst),
        .clear       (accept),
        .capture     (in_run),
        .active_mask (active_mask),
        .core_done   (bus.core_done),
        .done_mask   (bus.done_mask),
        .all_done    (all_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mode         <= BROADCAST;
            active_mask  <= '0;
            idx          <= '0;
            startN_q     <= 1'b1;
            core_start_r <= '0;
            ready_r      <= 1'b1;
            done_r       <= 1'b0;
            timed_out_r  <= 1'b0;
            cycle_cnt    <= '0;
        end else begin
            startN_q     <= bus.startN;
            core_start_r <= '0;
            if (in_run && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        active_mask <= bus.core_enable;
                        mode        <= bus.mode_stagger ? STAGGER : BROADCAST;
                        idx         <= '0;
                        cycle_cnt   <= '0;
                        done_r      <= 1'b0;
                        timed_out_r <= 1'b0;
                        ready_r     <= 1'b0;
                        state       <= LAUNCH;
                        core_start_r <= bus.mode_stagger ? (bus.core_enable & CORE_COUNT'(1))
                                                         : bus.core_enable;
                    end
                end
                LAUNCH: begin
                    if (check_done && all_done) begin
                        state   <= DONE;
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                    end else if (timeout_hit) begin
                        state       <= DONE;
                        done_r      <= 1'b1;
                        ready_r     <= 1'b1;
                        timed_out_r <= 1'b1;
                    end else if ((mode == BROADCAST) || (idx == LAST_IDX)) begin
                        state <= RUN;
                    end else begin
                        // Disabled indices still burn their slot so core i always starts at k+1+i.
                        idx          <= idx + 1'b1;
                        core_start_r <= active_mask & (CORE_COUNT'(1) << (idx + 1'b1));
                    end
                end
                RUN: begin
                    if (all_done) begin
                        state   <= DONE;
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                    end else if (timeout_hit) begin
                        state       <= DONE;
                        done_r      <= 1'b1;
                        ready_r     <= 1'b1;
                        timed_out_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.core_start      = core_start_r;
    assign bus.processor_ready = ready_r;
    assign bus.processDone     = done_r;
    assign bus.timed_out       = timed_out_r;
    assign bus.cycle_count     = cycle_cnt;
endmodule
